systolic_mac_array_os: RTL

//  Parametrised output-stationary systolic MAC array; successor to the fixed-size mac_array.

---
 rtl/systolic_mac_array_os.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_mac_array_os.sv
// Output-stationary systolic MAC array: skewed A/B operand injection, PE grid of
// accumulators, fixed-length flush, then row-serial drain under backpressure.
module systolic_mac_array_os #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DW       = 8,
    parameter int AW       = 24,
    parameter int SATURATE = 0,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [ROWS*DW-1:0]   a_data,
    input  logic [COLS*DW-1:0]   b_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_row,
    output logic [COLS*AW-1:0]   out_data,
    output logic [COLS-1:0]      out_sat,
    output logic                 busy
);

    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int CW        = $clog2(ROWS + COLS);
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    generate
        if (AW < 2*DW) begin : g_aw_check
            $error("systolic_mac_array_os: AW must be at least 2*DW");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [RW-1:0]   row, row_n;
    logic            accept;
    logic            clear;

    assign in_ready  = (state == S_IDLE) || (state == S_COMPUTE);
    assign out_valid = (state == S_DRAIN);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign clear     = accept && (state == S_IDLE);
    assign out_row   = row;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        case (state)
            S_IDLE, S_COMPUTE: begin
                if (accept) begin
                    state_n = in_last ? S_FLUSH : S_COMPUTE;
                    cnt_n   = '0;
                end
            end
            S_FLUSH: begin
                if (cnt == CW'(FLUSH_LEN - 1)) begin
                    state_n = S_DRAIN;
                    row_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row == RW'(ROWS - 1)) begin
                        state_n = S_IDLE;
                        row_n   = '0;
                    end else begin
                        row_n = row + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            row   <= row_n;
        end
    end

    // Edge-of-array operands after skew: lane r of A arrives r cycles late, lane c of B c cycles late.
    logic [ROWS-1:0][DW-1:0] a_lane;
    logic [ROWS-1:0]         a_lane_v;
    logic [COLS-1:0][DW-1:0] b_lane;
    logic [COLS-1:0]         b_lane_v;

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DW-1:0] tok;
        assign tok = accept ? a_data[r*DW +: DW] : '0;
        if (r == 0) begin : g_direct
            assign a_lane[r]   = tok;
            assign a_lane_v[r] = accept;
        end else begin : g_delay
            logic [r-1:0][DW-1:0] sk_d;
            logic [r-1:0]         sk_v;
            // NOTE: skew and accumulator state is reset so a discarded tile leaves no valid residue.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sk_d <= '0;
                    sk_v <= '0;
                end else begin
                    sk_d[0] <= tok;
                    sk_v[0] <= accept;
                    for (int s = 1; s < r; s++) begin
                        sk_d[s] <= sk_d[s-1];
                        sk_v[s] <= sk_v[s-1];
                    end
                end
            end
            assign a_lane[r]   = sk_d[r-1];
            assign a_lane_v[r] = sk_v[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DW-1:0] tok;
        assign tok = accept ? b_data[c*DW +: DW] : '0;
        if (c == 0) begin : g_direct
            assign b_lane[c]   = tok;
            assign b_lane_v[c] = accept;
        end else begin : g_delay
            logic [c-1:0][DW-1:0] sk_d;
            logic [c-1:0]         sk_v;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sk_d <= '0;
                    sk_v <= '0;
                end else begin
                    sk_d[0] <= tok;
                    sk_v[0] <= accept;
                    for (int s = 1; s < c; s++) begin
                        sk_d[s] <= sk_d[s-1];
                        sk_v[s] <= sk_v[s-1];
                    end
                end
            end
            assign b_lane[c]   = sk_d[c-1];
            assign b_lane_v[c] = sk_v[c-1];
        end
    end

    // pa/pb are the operands seen by each PE; the hop register sits on the receiving PE.
    logic [ROWS-1:0][COLS-1:0][DW-1:0] pa, pb;
    logic [ROWS-1:0][COLS-1:0]         pav, pbv;
    logic [ROWS-1:0][COLS-1:0][AW-1:0] acc;
    logic [ROWS-1:0][COLS-1:0]         sat;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            if (c == 0) begin : g_a_edge
                assign pa[r][c]  = a_lane[r];
                assign pav[r][c] = a_lane_v[r];
            end else begin : g_a_hop
                logic [DW-1:0] d;
                logic          v;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        d <= '0;
                        v <= 1'b0;
                    end else begin
                        d <= pa[r][c-1];
                        v <= pav[r][c-1];
                    end
                end
                assign pa[r][c]  = d;
                assign pav[r][c] = v;
            end

            if (r == 0) begin : g_b_edge
                assign pb[r][c]  = b_lane[c];
                assign pbv[r][c] = b_lane_v[c];
            end else begin : g_b_hop
                logic [DW-1:0] d;
                logic          v;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        d <= '0;
                        v <= 1'b0;
                    end else begin
                        d <= pb[r-1][c];
                        v <= pbv[r-1][c];
                    end
                end
                assign pb[r][c]  = d;
                assign pbv[r][c] = v;
            end

            logic [2*DW-1:0] ax, bx, prod;
            logic [AW:0]     sum;
            logic [AW-1:0]   base, acc_q, acc_d;
            logic            sat_q, sat_d;

            assign ax   = {{DW{pa[r][c][DW-1]}}, pa[r][c]};
            assign bx   = {{DW{pb[r][c][DW-1]}}, pb[r][c]};
            assign prod = ax * bx;
            // The tile's first beat reaches PE(0,0) in the clearing cycle, so clear selects the base.
            assign base = clear ? '0 : acc_q;
            assign sum  = {base[AW-1], base} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};

            always_comb begin
                acc_d = base;
                sat_d = sat_q && !clear;
                if (pav[r][c] && pbv[r][c]) begin
                    if ((SATURATE != 0) && (sum[AW] != sum[AW-1])) begin
                        acc_d = sum[AW] ? ACC_MIN : ACC_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[AW-1:0];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                    sat_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    sat_q <= sat_d;
                end
            end

            assign acc[r][c] = acc_q;
            assign sat[r][c] = sat_q;
        end
    end

    always_comb begin
        out_data = '0;
        out_sat  = '0;
        for (int c = 0; c < COLS; c++) begin
            out_data[c*AW +: AW] = acc[row][c];
            out_sat[c]           = sat[row][c];
        end
    end

endmodule
